// File: rtl/ps2_rx_fifo_if.sv
// Byte-read bus between the PS/2 receiver and the scan-code decoder.
// The decoder (master) strobes rd; the receiver (slave) presents queued bytes and status pulses.
`timescale 1ns/1ps
interface ps2_rx_fifo_if;
    logic       rd;
    logic [7:0] scan_code;
    logic       data_ready;
    logic       parity_err;
    logic       overflow;

    modport master (
        output rd,
        input  scan_code,
        input  data_ready,
        input  parity_err,
        input  overflow
    );

    modport slave (
        input  rd,
        output scan_code,
        output data_ready,
        output parity_err,
        output overflow
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: sync + deglitch, 11-bit frame check, byte FIFO with rd strobe.
// Optional macro PS2_HOST_INHIBIT_EN holds the PS/2 clock low while the FIFO is full.
`timescale 1ns/1ps
module ps2_rx_fifo #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 14000,
    parameter int unsigned FIFO_AW     = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ps2_clk_i,
    input  logic          ps2_data_i,
    output logic          ps2_clk_oe,
    ps2_rx_fifo_if.slave  bus
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned FCW   = $clog2(FILTER_LEN + 1);
    localparam int unsigned TCW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FIFO_AW:0] CNT_FULL = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic           r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic           r_fclk;
    logic [FCW-1:0] r_fcnt;
    logic           w_ftog, w_fall;

    state_e         r_state, w_state_d;
    logic [7:0]     r_shift;
    logic [2:0]     r_bitcnt;
    logic           r_par;
    logic [TCW-1:0] r_tocnt;
    logic           w_timeout, w_frame_ok, w_push, w_perr;

    logic [7:0]     r_mem [DEPTH];
    logic [FIFO_AW:0] r_wr_ptr, r_rd_ptr, r_count, w_count_d;
    logic           w_full, w_wr, w_ovf, w_pop;

    logic [7:0]     r_scan;
    logic           r_data_ready, r_perr, r_ovf;

    // Synchronisers and clock deglitcher; fclk moves only after FILTER_LEN disagreeing samples.
    assign w_ftog = (r_clk_s2 != r_fclk) && (r_fcnt == FCW'(FILTER_LEN - 1));
    assign w_fall = w_ftog && r_fclk;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_fclk   <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_clk_s1 <= ps2_clk_i;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data_i;
            r_dat_s2 <= r_dat_s1;
            if (r_clk_s2 == r_fclk || w_ftog) begin
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
            if (w_ftog) begin
                r_fclk <= r_clk_s2;
            end
        end
    end

    assign w_timeout = (r_state != StIdle) && !w_fall && (r_tocnt == TCW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (w_timeout) begin
            w_state_d = StIdle;
        end else if (w_fall) begin
            case (r_state)
                StIdle:   if (!r_dat_s2) w_state_d = StData;
                StData:   if (r_bitcnt == 3'd7) w_state_d = StParity;
                StParity: w_state_d = StStop;
                StStop:   w_state_d = StIdle;
                default:  w_state_d = StIdle;
            endcase
        end
    end

    // Good frame: stop=1 and odd parity over data+parity.
    always_comb begin
        w_frame_ok = r_dat_s2 && (^{r_shift, r_par});
        w_push     = (r_state == StStop) && w_fall && w_frame_ok;
        w_perr     = (r_state == StStop) && w_fall && !w_frame_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_par    <= 1'b0;
            r_tocnt  <= '0;
        end else begin
            if (r_state == StIdle || w_fall || w_timeout) begin
                r_tocnt <= '0;
            end else begin
                r_tocnt <= r_tocnt + 1'b1;
            end
            if (w_fall) begin
                case (r_state)
                    StIdle: r_bitcnt <= '0;
                    StData: begin
                        r_shift  <= {r_dat_s2, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                    StParity: r_par <= r_dat_s2;
                    default: ;
                endcase
            end
        end
    end

    // FIFO: a push into a full buffer is dropped even if a pop happens in the same cycle.
    assign w_full = (r_count == CNT_FULL);
    assign w_wr   = w_push && !w_full;
    assign w_ovf  = w_push && w_full;
    assign w_pop  = bus.rd && (r_count != '0);

    always_comb begin
        w_count_d = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_d = r_count + 1'b1;
            2'b01:   w_count_d = r_count - 1'b1;
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_scan       <= 8'h00;
            r_data_ready <= 1'b0;
            r_perr       <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_scan   <= r_mem[r_rd_ptr[FIFO_AW-1:0]];
            end
            r_count      <= w_count_d;
            r_data_ready <= (w_count_d != '0);
            r_perr       <= w_perr;
            r_ovf        <= w_ovf;
        end
    end

    assign bus.scan_code  = r_scan;
    assign bus.data_ready = r_data_ready;
    assign bus.parity_err = r_perr;
    assign bus.overflow   = r_ovf;

`ifdef PS2_HOST_INHIBIT_EN
    logic r_oe;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_oe <= 1'b0;
        end else begin
            r_oe <= (w_count_d == CNT_FULL);
        end
    end

    assign ps2_clk_oe = r_oe;
`else
    assign ps2_clk_oe = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: PS/2 device model, byte scoreboard and status pulse counters.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

    localparam int unsigned TO = 600;
    localparam int unsigned H  = 40;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic oe;

    ps2_rx_fifo_if bus();

    ps2_rx_fifo #(
        .FILTER_LEN (8),
        .TIMEOUT_CYC(TO),
        .FIFO_AW    (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk_i (ps2_clk),
        .ps2_data_i(ps2_data),
        .ps2_clk_oe(oe),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        bit         bad_par;
        bit         bad_stop;
        bit         good;
    } vec_t;

    int total = 0;
    int bad = 0;
    int perr_cnt = 0;
    int ovf_cnt = 0;
    int exp_perr = 0;
    int exp_ovf = 0;
    int m_count = 0;
    logic [7:0] exp_q[$];
    vec_t tbl[7];

    // Count every cycle a pulse is high, so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (bus.parity_err) perr_cnt <= perr_cnt + 1;
        if (bus.overflow)   ovf_cnt  <= ovf_cnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: sim time exceeded, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            tick(H);
            ps2_clk = 1'b0;
            tick(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic par;
        logic stp;
        par = (~^d) ^ bad_par;
        stp = ~bad_stop;
        send_bits({stp, par, d, 1'b0}, 11);
        tick(20);
        if (bad_par || bad_stop) begin
            exp_perr++;
        end else if (m_count < 8) begin
            exp_q.push_back(d);
            m_count++;
        end else begin
            exp_ovf++;
        end
    endtask

    // Decoder-style read: strobe rd for one clk, sample scan_code two clocks after the strobe.
    task automatic do_read(input string name);
        logic [7:0] exp;
        bus.rd = 1'b1;
        tick(1);
        bus.rd = 1'b0;
        tick(1);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got read want no read (scoreboard empty)", name);
        end else begin
            exp = exp_q.pop_front();
            m_count--;
            chk(name, {24'd0, bus.scan_code}, {24'd0, exp});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(4);
        reset = 1'b0;
        exp_q.delete();
        m_count = 0;
        tick(2);
    endtask

    initial begin
        bus.rd = 1'b0;
        tbl[0] = '{d: 8'h1C, bad_par: 1'b0, bad_stop: 1'b0, good: 1'b1};
        tbl[1] = '{d: 8'h1C, bad_par: 1'b1, bad_stop: 1'b0, good: 1'b0};
        tbl[2] = '{d: 8'hAA, bad_par: 1'b0, bad_stop: 1'b0, good: 1'b1};
        tbl[3] = '{d: 8'h00, bad_par: 1'b0, bad_stop: 1'b1, good: 1'b0};
        tbl[4] = '{d: 8'hFF, bad_par: 1'b0, bad_stop: 1'b0, good: 1'b1};
        tbl[5] = '{d: 8'h80, bad_par: 1'b1, bad_stop: 1'b0, good: 1'b0};
        tbl[6] = '{d: 8'h80, bad_par: 1'b0, bad_stop: 1'b0, good: 1'b1};

        do_reset();
        chk("rst_scan", {24'd0, bus.scan_code}, 32'h00);
        chk("rst_ready", {31'd0, bus.data_ready}, 32'd0);
        chk("rst_perr", {31'd0, bus.parity_err}, 32'd0);
        chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
        chk("rst_oe", {31'd0, oe}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i].d, tbl[i].bad_par, tbl[i].bad_stop);
            chk($sformatf("tbl%0d_ready", i), {31'd0, bus.data_ready}, {31'd0, tbl[i].good});
            chk($sformatf("tbl%0d_perr", i), perr_cnt, exp_perr);
            if (tbl[i].good) do_read($sformatf("tbl%0d_scan", i));
            chk($sformatf("tbl%0d_empty", i), {31'd0, bus.data_ready}, 32'd0);
        end

        // Back-to-back frames with no reads in between.
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h74, 1'b0, 1'b0);
        chk("b2b_ready", {31'd0, bus.data_ready}, 32'd1);
        do_read("b2b_e0");
        chk("b2b_ready1", {31'd0, bus.data_ready}, 32'd1);
        do_read("b2b_f0");
        do_read("b2b_74");
        chk("b2b_empty", {31'd0, bus.data_ready}, 32'd0);

        // rd on an empty FIFO leaves scan_code alone.
        bus.rd = 1'b1;
        tick(1);
        bus.rd = 1'b0;
        tick(1);
        chk("rd_empty_hold", {24'd0, bus.scan_code}, 32'h74);
        chk("rd_empty_ready", {31'd0, bus.data_ready}, 32'd0);

        // Fill the FIFO, then one more frame overflows.
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0);
`ifdef PS2_HOST_INHIBIT_EN
        chk("full_oe", {31'd0, oe}, 32'd1);
`endif
        send_frame(8'h09, 1'b0, 1'b0);
        chk("ovf_count", ovf_cnt, exp_ovf);
        chk("ovf_expected", exp_ovf, 1);
`ifdef PS2_HOST_INHIBIT_EN
        bus.rd = 1'b1;
        tick(1);
        bus.rd = 1'b0;
        chk("oe_release", {31'd0, oe}, 32'd0);
        tick(1);
        chk("ovf_scan1", {24'd0, bus.scan_code}, {24'd0, exp_q.pop_front()});
        m_count--;
`else
        do_read("ovf_scan1");
`endif
        for (int i = 2; i <= 8; i++) do_read($sformatf("ovf_scan%0d", i));
        chk("ovf_empty", {31'd0, bus.data_ready}, 32'd0);

        // Truncated frame, long idle, then a clean frame.
        send_bits(11'b000_0000_1010, 5);
        tick(2 * TO);
        chk("to_ready_mid", {31'd0, bus.data_ready}, 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0);
        chk("to_perr", perr_cnt, exp_perr);
        chk("to_ready", {31'd0, bus.data_ready}, 32'd1);
        do_read("to_scan");
        chk("to_empty", {31'd0, bus.data_ready}, 32'd0);

        // Short low glitch on the clock pin with data low must not start a frame.
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        tick(30);
        chk("glitch_ready", {31'd0, bus.data_ready}, 32'd0);
        send_frame(8'h33, 1'b0, 1'b0);
        chk("glitch_perr", perr_cnt, exp_perr);
        do_read("glitch_scan");

        // Reset with bytes queued and a frame half received.
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        send_bits(11'b000_0000_0110, 3);
        do_reset();
        chk("mid_rst_ready", {31'd0, bus.data_ready}, 32'd0);
        chk("mid_rst_scan", {24'd0, bus.scan_code}, 32'h00);
        send_frame(8'h3C, 1'b0, 1'b0);
        chk("post_rst_perr", perr_cnt, exp_perr);
        do_read("post_rst_scan");
        chk("post_rst_empty", {31'd0, bus.data_ready}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- PS/2 device-to-host receiver feeding the scan-code decoder that builds the Specialist KeyMap/Func matrix.
- Synchronises and deglitches the PS/2 clock and data lines, deserialises 11-bit frames and checks start, odd parity and stop bits.
- Queues good bytes in a small FIFO.
- Presents bytes through a level data_ready plus a one-cycle rd strobe. This matches the decoder's read sequence: assert rd, then sample the byte two clocks later.

Parameters:
- FILTER_LEN, 8: consecutive equal samples required before the filtered PS/2 clock changes state.
- TIMEOUT_CYC, 14000: max clk cycles between filtered falling edges inside a frame (~1 ms at 14 MHz).
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW = 8 bytes.

Ports:
- clk  in  1  system clock, ≥14 MHz
- reset  in  1  synchronous, active-high
- ps2_clk_i  in  1  raw PS/2 clock pin level
- ps2_data_i  in  1  raw PS/2 data pin level
- rd  in  1  pop strobe, one clk wide
- scan_code  out  8  last popped byte
- data_ready  out  1  high while FIFO not empty
- parity_err  out  1  one-clk pulse on a rejected frame
- overflow  out  1  one-clk pulse when a good frame is dropped
- ps2_clk_oe  out  1  drive PS/2 clock low (open-drain enable)

Behaviour:
- Interface: reset, synchronous, active-high; clock clk. All state is updated on posedge clk.
- Input path:
  - Both pins pass through 2-FF synchronisers.
  - Filtered clock (fclk) toggles only after FILTER_LEN identical synchronised samples.
  - A falling edge is fclk 1→0. Data is sampled from the synchronised data line in that same cycle.
- Frame FSM:
  - IDLE: on a falling edge with data=0, go to DATA with bitcnt=0. A falling edge with data=1 is ignored.
  - DATA: shift in LSB first. After the 8th bit, go to PARITY.
  - PARITY: store the bit, go to STOP.
  - STOP: on the falling edge, evaluate the frame.
    - Good frame: stop=1 AND XOR(data, parity)=1. Push to the FIFO and return to IDLE.
    - Otherwise: pulse parity_err for 1 clk, discard the frame, return to IDLE.
- Timeout:
  - Per-frame counter clears on each falling edge.
  - If it reaches TIMEOUT_CYC in any state other than IDLE: abort to IDLE, discard the partial byte, no error pulse.
- FIFO:
  - Circular buffer with wr_ptr, rd_ptr and count, each FIFO_AW+1 bits wide. Pointers wrap modulo depth.
  - Push while count==depth: byte dropped, overflow pulses 1 clk, FIFO unchanged.
  - Push and pop in the same cycle: both performed, count unchanged.
  - Pop on an empty FIFO is allowed: the push occurring that same cycle is the only entry, so it is not popped.
- Read:
  - On posedge with rd=1 and count>0: scan_code <= mem[rd_ptr], rd_ptr++, count--.
  - scan_code is stable from the following cycle until the next accepted rd.
  - rd with count==0: ignored, scan_code holds.
- Output timing:
  - data_ready = (count!=0), registered. It goes high 1 clk after the stop-bit falling edge of a good frame.
  - It drops the cycle after the pop that empties the FIFO.
- Reset values:
  - Outputs: scan_code=8'h00, data_ready=0, parity_err=0, overflow=0, ps2_clk_oe=0.
  - Internal: FIFO empty, FSM=IDLE, filter state=1, synchronisers=1.
- Reset mid-frame or mid-FIFO: all content is lost and the partial frame is dropped. The next start bit after reset is received normally.

Optional Feature:
- Macro: PS2_HOST_INHIBIT_EN.
- When defined: ps2_clk_oe=1 while count==depth, so the host holds the PS/2 clock low and the keyboard buffers internally. It is released the cycle after a pop makes count<depth. overflow can still fire for a frame already in flight.
- When undefined: ps2_clk_oe is tied 0 and full-FIFO frames are dropped with an overflow pulse.

Test Plan:
- Send frame 0x1C (parity 0, stop 1) at a 12 kHz PS/2 clock → data_ready=1; pulse rd → scan_code=0x1C from the next clk; data_ready=0.
- Send 0x1C with parity bit 1 → parity_err one-clk pulse, data_ready stays 0.
- Send E0, F0, 74 back-to-back without rd → three pops yield E0, F0, 74 in order; data_ready falls after the third.
- Send 9 good frames 0x01..0x09, no rd, macro undefined → overflow pulses on the 9th; 8 pops return 0x01..0x08.
- Send a start bit plus 4 data bits, then hold the clock high for 2×TIMEOUT_CYC, then a full frame 0x5A → only 0x5A is received, no parity_err.
- Inject a 3-clk low glitch on ps2_clk_i while idle → no state change. With PS2_HOST_INHIBIT_EN and the FIFO filled to 8 → ps2_clk_oe=1; one rd → ps2_clk_oe=0 the next clk.
